// File: rtl/ieee754_pkg.sv
// Shared constants, field positions and stage types for the FP adder front end.
package ieee754_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = 28;
  localparam int D_W    = 5;

  localparam logic [31:0] IEEE754_QNAN = 32'h7FFF_FFFF;

  localparam int SIGN_POS = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;
  localparam int FRAC_LSB = 0;

  // Beyond this shift every significand bit lands in the sticky position.
  localparam int STICKY_LIM = 27;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  // Stage-1 register contents: ordered operands plus special-case result.
  typedef struct packed {
    logic [SIG_W-1:0] sig_l;
    logic [SIG_W-1:0] sig_s;
    logic [D_W-1:0]   d;
    logic [EXP_W-1:0] exp_l;
    logic             sign_l;
    logic             eff_sub;
    logic             zero_sign;
    logic             special;
    logic [31:0]      special_val;
  } s1_t;

  // Zero exponent flushes to a zero significand; otherwise hidden bit + 3 GRS bits.
  function automatic logic [SIG_W-1:0] unpack_sig(logic [31:0] f);
    return (f[EXP_MSB:EXP_LSB] == '0) ? '0 : {2'b01, f[FRAC_MSB:FRAC_LSB], 3'b000};
  endfunction

endpackage

// File: rtl/ieee754_shift_sticky.sv
// Right shift of a 28-bit significand; all bits shifted out are ORed into bit 0.
module ieee754_shift_sticky
  import ieee754_pkg::*;
(
  input  logic [SIG_W-1:0] in,
  input  logic [D_W-1:0]   amt,
  output logic [SIG_W-1:0] out
);

  logic [SIG_W-1:0] lost_mask;
  logic [SIG_W-1:0] shifted;
  logic             sticky;

  // Shift, then collapse the lost bits into the sticky position.
  always_comb begin
    shifted   = in >> amt;
    lost_mask = ~({SIG_W{1'b1}} << amt);
    sticky    = |(in & lost_mask);
    if (amt >= D_W'(STICKY_LIM)) begin
      shifted = '0;
      sticky  = |in;
    end
    out = {shifted[SIG_W-1:1], shifted[0] | sticky};
  end

endmodule

// File: rtl/ieee754_add_align.sv
// Two-stage elastic FP add front end: unpack/order/specials, then align and add.
module ieee754_add_align
  import ieee754_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_a,
  input  logic [31:0]       in_b,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [SIG_W-1:0]  out_sig,
  output logic              out_zero,
  output logic              out_special,
  output logic [31:0]       out_special_val
);

  logic [2:1]       vld_pipe_q;
  logic             s1_adv, s2_adv;
  s1_t              s1_d, s1_q;

  logic             sb, a_nan, b_nan, a_inf, b_inf, a_big;
  logic [EXP_W-1:0] ea, eb, ediff;

  logic [SIG_W-1:0] s_al, mag;
  logic             sign_d, sign_q, zero_d, zero_q, spec_d, spec_q;
  logic [EXP_W-1:0] exp_d, exp_q;
  logic [SIG_W-1:0] sig_d, sig_q;
  logic [31:0]      sval_d, sval_q;

  assign s2_adv    = !vld_pipe_q[2] || out_ready;
  assign s1_adv    = !vld_pipe_q[1] || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = vld_pipe_q[2];

  // Stage 1: classify, order by magnitude, saturate the exponent gap.
  always_comb begin
    sb    = in_b[SIGN_POS] ^ in_sub;
    ea    = in_a[EXP_MSB:EXP_LSB];
    eb    = in_b[EXP_MSB:EXP_LSB];
    a_nan = (ea == EXP_MAX) && (in_a[FRAC_MSB:FRAC_LSB] != '0);
    b_nan = (eb == EXP_MAX) && (in_b[FRAC_MSB:FRAC_LSB] != '0);
    a_inf = (ea == EXP_MAX) && (in_a[FRAC_MSB:FRAC_LSB] == '0);
    b_inf = (eb == EXP_MAX) && (in_b[FRAC_MSB:FRAC_LSB] == '0);
    a_big = in_a[EXP_MSB:0] >= in_b[EXP_MSB:0];
    ediff = a_big ? (ea - eb) : (eb - ea);

    s1_d           = '0;
    s1_d.sig_l     = a_big ? unpack_sig(in_a) : unpack_sig(in_b);
    s1_d.sig_s     = a_big ? unpack_sig(in_b) : unpack_sig(in_a);
    s1_d.d         = (|ediff[EXP_W-1:D_W]) ? '1 : ediff[D_W-1:0];
    s1_d.exp_l     = a_big ? ea : eb;
    s1_d.sign_l    = a_big ? in_a[SIGN_POS] : sb;
    s1_d.eff_sub   = in_a[SIGN_POS] ^ sb;
    s1_d.zero_sign = in_a[SIGN_POS] & sb;

    if (a_nan || b_nan || (a_inf && b_inf && (in_a[SIGN_POS] != sb))) begin
      s1_d.special     = 1'b1;
      s1_d.special_val = IEEE754_QNAN;
    end else if (a_inf) begin
      s1_d.special     = 1'b1;
      s1_d.special_val = {in_a[SIGN_POS], EXP_MAX, {FRAC_W{1'b0}}};
    end else if (b_inf) begin
      s1_d.special     = 1'b1;
      s1_d.special_val = {sb, EXP_MAX, {FRAC_W{1'b0}}};
    end
  end

  ieee754_shift_sticky u_shift (
    .in  (s1_q.sig_s),
    .amt (s1_q.d),
    .out (s_al)
  );

  // Stage 2: magnitude add/sub; specials force the numeric fields to zero.
  always_comb begin
    mag    = s1_q.eff_sub ? (s1_q.sig_l - s_al) : (s1_q.sig_l + s_al);
    zero_d = (mag == '0);
    sign_d = zero_d ? (!s1_q.eff_sub && s1_q.zero_sign) : s1_q.sign_l;
    sig_d  = mag;
    exp_d  = s1_q.exp_l;
    spec_d = s1_q.special;
    sval_d = s1_q.special_val;
    if (s1_q.special) begin
      zero_d = 1'b0;
      sign_d = 1'b0;
      sig_d  = '0;
      exp_d  = '0;
    end
  end

  // Handshake valids: each stage refills whenever it advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
    end else begin
      if (s2_adv) vld_pipe_q[2] <= vld_pipe_q[1];
      if (s1_adv) vld_pipe_q[1] <= in_valid;
    end
  end

  // Stage-1 data captures operands only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 s1_q <= '0;
    else if (s1_adv && in_valid) s1_q <= s1_d;
  end

  // Output registers load only when a valid stage-1 result moves forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      sig_q  <= '0;
      zero_q <= 1'b0;
      spec_q <= 1'b0;
      sval_q <= '0;
    end else if (s2_adv && vld_pipe_q[1]) begin
      sign_q <= sign_d;
      exp_q  <= exp_d;
      sig_q  <= sig_d;
      zero_q <= zero_d;
      spec_q <= spec_d;
      sval_q <= sval_d;
    end
  end

  assign out_sign        = sign_q;
  assign out_exp         = exp_q;
  assign out_sig         = sig_q;
  assign out_zero        = zero_q;
  assign out_special     = spec_q;
  assign out_special_val = sval_q;

endmodule

// File: tb/tb_ieee754_add_align.sv
// Scoreboard bench for ieee754_add_align with an arithmetic reference model.
module tb_ieee754_add_align;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_ready, out_valid, out_sign, out_zero, out_special;
  logic [7:0]  out_exp;
  logic [27:0] out_sig;
  logic [31:0] out_special_val;

  int n_checks = 0, n_fail = 0;
  bit rand_rdy = 1'b0;

  typedef struct packed {
    bit        sign;
    bit [7:0]  exp;
    bit [27:0] sig;
    bit        zero;
    bit        special;
    bit [31:0] sval;
  } res_t;

  typedef struct packed {
    bit [31:0] a;
    bit [31:0] b;
    bit        sub;
  } op_t;

  res_t q[$];
  res_t e;

  ieee754_add_align dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp),
    .out_sig(out_sig), .out_zero(out_zero), .out_special(out_special),
    .out_special_val(out_special_val)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Reference: integer magnitudes with scaled significands and explicit sticky.
  function automatic res_t model(bit [31:0] a, bit [31:0] b, bit sub);
    res_t   r;
    bit     sa, sbe, a_nan, b_nan, a_inf, b_inf, eff_sub, sl;
    int     ea, eb, el, es, d;
    longint ma, mb, ml, ms, unit, al, mag;
    r   = '0;
    sa  = a[31];
    sbe = b[31] ^ sub;
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    a_nan = (ea == 255) && (a[22:0] != 0);
    b_nan = (eb == 255) && (b[22:0] != 0);
    a_inf = (ea == 255) && (a[22:0] == 0);
    b_inf = (eb == 255) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && sa != sbe)) begin
      r.special = 1; r.sval = 32'h7FFF_FFFF; return r;
    end
    if (a_inf || b_inf) begin
      r.special = 1;
      r.sval = (a_inf ? sa : sbe) ? 32'hFF80_0000 : 32'h7F80_0000;
      return r;
    end
    ma = (ea == 0) ? 0 : (longint'(a[22:0]) + 64'd8388608) * 8;
    mb = (eb == 0) ? 0 : (longint'(b[22:0]) + 64'd8388608) * 8;
    if (a[30:0] >= b[30:0]) begin
      ml = ma; ms = mb; el = ea; es = eb; sl = sa;
    end else begin
      ml = mb; ms = ma; el = eb; es = ea; sl = sbe;
    end
    d = el - es;
    if (d > 31) d = 31;
    unit = longint'(1) << d;
    al = ms / unit;
    if (ms % unit != 0) al = al | 1;
    eff_sub = sa ^ sbe;
    mag = eff_sub ? ml - al : ml + al;
    r.sig  = mag[27:0];
    r.exp  = el[7:0];
    r.zero = (mag == 0);
    r.sign = r.zero ? (!eff_sub && sa && sbe) : sl;
    return r;
  endfunction

  // Stimulus side: every accepted operand pair queues its expected result.
  always @(negedge clk) begin
    #4;
    if (rst_n && in_valid && in_ready) q.push_back(model(in_a, in_b, in_sub));
  end

  // Monitor: compare each transferred result against the queue head.
  always @(negedge clk) begin
    #4;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_output: actual sig %h required no result", out_sig);
      end else begin
        e = q.pop_front();
        chk("special",     64'(out_special),     64'(e.special));
        chk("special_val", 64'(out_special_val), 64'(e.sval));
        chk("sig",         64'(out_sig),         64'(e.sig));
        chk("exp",         64'(out_exp),         64'(e.exp));
        chk("zero",        64'(out_zero),        64'(e.zero));
        if (!e.special) chk("sign", 64'(out_sign), 64'(e.sign));
      end
    end
  end

  always @(negedge clk) if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(bit [31:0] a, bit [31:0] b, bit sub);
    int w = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
    #4;
    while (!in_ready) begin
      @(negedge clk); #4; w++;
      if (w > 200) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout: actual in_ready 0 required 1");
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int w = 0;
    while (q.size() != 0 && w < 300) begin @(negedge clk); w++; end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: actual %0d pending required 0", q.size());
    end
  endtask

  function automatic bit [31:0] rnd_fp(bit [7:0] near);
    bit [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 11))
      0:       v[30:23] = 8'h00;
      1:       v[30:23] = 8'hFF;
      2:       begin v[30:23] = 8'hFF; v[22:0] = '0; end
      3:       v[22:0] = '0;
      4, 5, 6: v[30:23] = near + 8'($urandom_range(0, 6)) - 8'd3;
      7, 8:    v[30:23] = near + 8'($urandom_range(0, 40)) - 8'd20;
      default: ;
    endcase
    return v;
  endfunction

  op_t dir [12] = '{
    '{32'h3F80_0000, 32'h3F80_0000, 1'b0},
    '{32'h3FC0_0000, 32'h3F40_0000, 1'b0},
    '{32'h3F80_0000, 32'h3F80_0000, 1'b1},
    '{32'h8000_0000, 32'h8000_0000, 1'b0},
    '{32'h3F80_0000, 32'h3080_0000, 1'b0},
    '{32'h7F80_0000, 32'hFF80_0000, 1'b0},
    '{32'h7FC0_0000, 32'h3F80_0000, 1'b0},
    '{32'h7F80_0000, 32'h3F80_0000, 1'b1},
    '{32'h3F80_0000, 32'hBF80_0000, 1'b0},
    '{32'h0040_0000, 32'h3F80_0000, 1'b0},
    '{32'h4000_0000, 32'h4040_0000, 1'b1},
    '{32'h3F80_0001, 32'h3F80_0000, 1'b1}
  };

  res_t m1;
  bit [31:0] ra, rb;

  initial begin
    // Reset state
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sig",   64'(out_sig),   64'd0);
    chk("rst_out_exp",   64'(out_exp),   64'd0);
    chk("rst_out_sval",  64'(out_special_val), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;

    // Directed operands from the test plan plus a few edge cases
    foreach (dir[i]) send(dir[i].a, dir[i].b, dir[i].sub);
    idle();
    wait_drain();

    // Backpressure: two accepts fill the pipe, outputs hold the first result
    out_ready = 1'b0;
    m1 = model(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    send(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 32'h3F80_0000, 1'b0);
    in_valid = 1'b1; in_a = 32'h4040_0000; in_b = 32'hC000_0000; in_sub = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #4;
      chk("bp_in_ready",  64'(in_ready),  64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_sig",  64'(out_sig),   64'(m1.sig));
      chk("bp_hold_exp",  64'(out_exp),   64'(m1.exp));
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(32'h4040_0000, 32'hC000_0000, 1'b0);
    send(32'h3E80_0000, 32'h3F00_0000, 1'b1);
    idle();
    wait_drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send(32'h4000_0000, 32'h3F80_0000, 1'b0);
    send(32'h4040_0000, 32'h3F80_0000, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_sig",   64'(out_sig),   64'd0);
    chk("mid_rst_out_exp",   64'(out_exp),   64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    send(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    in_valid = 1'b0;
    #4;
    chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge clk); #4;
    chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
    chk("lat_sig",          64'(out_sig),   64'h800_0000);
    chk("lat_exp",          64'(out_exp),   64'h7F);
    @(negedge clk);
    wait_drain();

    // Randomized traffic with random backpressure and input gaps
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      rb = rnd_fp(8'($urandom_range(1, 254)));
      ra = ($urandom_range(0, 15) == 0) ? {$urandom_range(0, 1) == 1, rb[30:0]}
                                        : rnd_fp(rb[30:23]);
      send(ra, rb, 1'($urandom_range(0, 1)));
    end
    idle();
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
